fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage of the pipelined LEGv8 core: PC register, next-PC selection, instruction memory addressing and the IF/ID pipeline register.
- Drives the word-addressed instruction ROM (7-bit address, combinational read, enable-gated output).
- Registers the returned instruction and its PC into the decode stage.
- Applies load-use stalls from the hazard unit, and branch redirect/flush from the MEM stage.

Parameters:
- N, 64, PC and branch-target width.
- IW, 32, instruction width; must equal instruction memory data width.
- AW, 7, instruction memory word-address width; ROM depth 2^AW words.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- stall_F  input  1  hold PC and IF/ID contents (load-use hazard).
- flush_D  input  1  load a bubble into IF/ID at this edge.
- pc_src  input  1  branch taken, resolved in MEM; redirect PC.
- pc_branch  input  N  branch target byte address.
- imem_addr  output  AW  word address to instruction memory.
- imem_en  output  1  instruction memory enable.
- imem_q  input  IW  instruction word, combinational from imem_addr.
- instr_D  output  IW  IF/ID instruction.
- pc_D  output  N  IF/ID PC of instr_D.
- valid_D  output  1  IF/ID holds a real instruction (0 = bubble).
- fetch_count  output  32  number of valid instructions written into IF/ID.

Behaviour:
- Reset (async, any time, including mid-stall or mid-redirect): PC=0, instr_D=0, pc_D=0, valid_D=0, fetch_count=0, state=BOOT. imem_en=0 while reset is asserted.
- FSM states:
  - BOOT: exactly one cycle after reset deasserts. imem_en=0, PC held at 0, IF/ID loads a bubble, inputs ignored. Transition to RUN unconditionally.
  - RUN: imem_en=1. No exit except reset.
- Addressing: imem_addr = PC[AW+1:2]. PC[1:0] is ignored, with no alignment check. PC bits above AW+1 are not decoded, so addresses alias modulo 2^AW words; PC 0x1FC gives addr 127, and 0x200 gives addr 0.
- Combinational read: imem_q is valid in the same cycle as imem_addr. IF/ID captures it at the next rising edge. Latency from PC to instr_D is 1 cycle.
- RUN edge priority, highest first:
  1. pc_src=1: PC<=pc_branch, IF/ID<=bubble. Overrides stall_F and flush_D.
  2. stall_F=1: PC and IF/ID hold. A simultaneous flush_D still loads the bubble into IF/ID; PC still holds.
  3. flush_D=1: PC<=PC+4, IF/ID<=bubble.
  4. Otherwise: PC<=PC+4, instr_D<=imem_q, pc_D<=PC, valid_D<=1.
- Bubble means instr_D=0, pc_D=0, valid_D=0.
- PC arithmetic is N-bit unsigned and wraps modulo 2^N (0xFFFF_FFFF_FFFF_FFFC+4 = 0).
- fetch_count increments only on a case-4 edge. It saturates at 0xFFFF_FFFF.
- No combinational path from stall_F, flush_D or pc_src to imem_addr. The redirect takes effect on the fetch in the cycle after the edge.

Test Plan:
- Reset/boot: imem model returns 0xA000_0000|addr; release reset. Required:
  - edge 1: BOOT, valid_D=0, imem_en=0.
  - edge 2: instr_D=0xA000_0000, pc_D=0, valid_D=1.
  - edge 3: instr_D=0xA000_0001, pc_D=4, fetch_count=2.
- Stall: assert stall_F for 3 cycles while pc_D=8. Required: instr_D=0xA000_0002, pc_D=8 and imem_addr=3 all held; fetch_count unchanged; on release, next edge gives pc_D=0xC.
- Redirect vs stall: pc_src=1, pc_branch=0x58, stall_F=1 same cycle. Required:
  - next edge: valid_D=0 and imem_addr=22.
  - following edge: instr_D=0xA000_0016, pc_D=0x58.
- Flush only: flush_D=1 at PC=0x10. Required: bubble in IF/ID, imem_addr=5 next cycle, fetch_count unchanged.
- Wrap: redirect to 0x1FC. Required: imem_addr=127, then imem_addr=0 with pc_D later 0x200 and instr_D=0xA000_0000.
- Async reset mid-operation: assert reset between edges during a stall. Required: all outputs go to reset values immediately, without waiting for clk; the BOOT cycle repeats after release.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the ROM (slave).
interface fetch_stage_if #(
  parameter int unsigned IW = 32,
  parameter int unsigned AW = 7
);
  logic [AW-1:0] imem_addr;
  logic          imem_en;
  logic [IW-1:0] imem_q;

  modport master (output imem_addr, output imem_en, input imem_q);
  modport slave  (input imem_addr, input imem_en, output imem_q);
endinterface

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC selection, ROM addressing and IF/ID register.
module fetch_stage #(
  parameter int unsigned N  = 64,
  parameter int unsigned IW = 32,
  parameter int unsigned AW = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_F,
  input  logic            flush_D,
  input  logic            pc_src,
  input  logic [N-1:0]    pc_branch,
  fetch_stage_if.master   imem,
  output logic [IW-1:0]   instr_D,
  output logic [N-1:0]    pc_D,
  output logic            valid_D,
  output logic [31:0]     fetch_count
);

  localparam int unsigned CW = 32;
  localparam logic [CW-1:0] COUNT_MAX = {CW{1'b1}};

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  logic [N-1:0]  pc;
  logic          en_q;

  // ROM address comes straight from the PC register; byte offset bits dropped.
  assign imem.imem_addr = pc[AW+1:2];
  assign imem.imem_en   = en_q;

  // FSM, PC and IF/ID register; redirect beats stall beats flush beats fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      pc          <= '0;
      en_q        <= 1'b0;
      instr_D     <= '0;
      pc_D        <= '0;
      valid_D     <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        BOOT: begin
          state   <= RUN;
          en_q    <= 1'b1;
          pc      <= '0;
          instr_D <= '0;
          pc_D    <= '0;
          valid_D <= 1'b0;
        end
        RUN: begin
          en_q <= 1'b1;
          if (pc_src) begin
            pc      <= pc_branch;
            instr_D <= '0;
            pc_D    <= '0;
            valid_D <= 1'b0;
          end else if (stall_F) begin
            // PC holds; a coincident flush still squashes the IF/ID entry.
            if (flush_D) begin
              instr_D <= '0;
              pc_D    <= '0;
              valid_D <= 1'b0;
            end
          end else if (flush_D) begin
            pc      <= pc + N'(4);
            instr_D <= '0;
            pc_D    <= '0;
            valid_D <= 1'b0;
          end else begin
            pc      <= pc + N'(4);
            instr_D <= imem.imem_q;
            pc_D    <= pc;
            valid_D <= 1'b1;
            if (fetch_count != COUNT_MAX) begin
              fetch_count <= fetch_count + CW'(1);
            end
          end
        end
        default: begin
          state <= BOOT;
          en_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a tagged combinational ROM model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_F;
  logic        flush_D;
  logic        pc_src;
  logic [63:0] pc_branch;
  logic [31:0] instr_D;
  logic [63:0] pc_D;
  logic        valid_D;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  fetch_stage_if #(.IW(32), .AW(7)) imem_bus ();

  // ROM returns 0xA000_0000 | word address, zero when disabled.
  assign imem_bus.imem_q = imem_bus.imem_en ? (32'hA000_0000 | 32'(imem_bus.imem_addr)) : 32'h0;

  fetch_stage #(.N(64), .IW(32), .AW(7)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall_F     (stall_F),
    .flush_D     (flush_D),
    .pc_src      (pc_src),
    .pc_branch   (pc_branch),
    .imem        (imem_bus),
    .instr_D     (instr_D),
    .pc_D        (pc_D),
    .valid_D     (valid_D),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall_F = 1'b0; flush_D = 1'b0; pc_src = 1'b0; pc_branch = '0;
    #3;
    checks++; if (imem_bus.imem_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", imem_bus.imem_en); end
    checks++; if (valid_D !== 1'b0 || pc_D !== 64'h0 || instr_D !== 32'h0) begin errors++; $display("FAIL reset_ifid: got v=%b pc=%h i=%h want zeros", valid_D, pc_D, instr_D); end
    checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
    tick(); tick();
    reset = 1'b0;
    checks++; if (imem_bus.imem_en !== 1'b0) begin errors++; $display("FAIL boot_en: got %b want 0", imem_bus.imem_en); end
    tick();
    checks++; if (valid_D !== 1'b0 || imem_bus.imem_en !== 1'b1) begin errors++; $display("FAIL edge1: got v=%b en=%b want v=0 en=1", valid_D, imem_bus.imem_en); end
    tick();
    checks++; if (instr_D !== 32'hA000_0000 || pc_D !== 64'h0 || valid_D !== 1'b1) begin errors++; $display("FAIL edge2: got i=%h pc=%h v=%b want A0000000 0 1", instr_D, pc_D, valid_D); end
    tick();
    checks++; if (instr_D !== 32'hA000_0001 || pc_D !== 64'h4 || fetch_count !== 32'd2) begin errors++; $display("FAIL edge3: got i=%h pc=%h cnt=%0d want A0000001 4 2", instr_D, pc_D, fetch_count); end
  endtask

  task automatic test_stall();
    tick();
    checks++; if (pc_D !== 64'h8) begin errors++; $display("FAIL stall_pre: got pc_D=%h want 8", pc_D); end
    stall_F = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (instr_D !== 32'hA000_0002 || pc_D !== 64'h8 || imem_bus.imem_addr !== 7'd3 || fetch_count !== 32'd3) begin
        errors++; $display("FAIL stall_hold%0d: got i=%h pc=%h a=%0d cnt=%0d want A0000002 8 3 3", i, instr_D, pc_D, imem_bus.imem_addr, fetch_count);
      end
    end
    stall_F = 1'b0;
    tick();
    checks++; if (pc_D !== 64'hC || fetch_count !== 32'd4) begin errors++; $display("FAIL stall_release: got pc=%h cnt=%0d want c 4", pc_D, fetch_count); end
  endtask

  task automatic test_flush();
    checks++; if (imem_bus.imem_addr !== 7'd4) begin errors++; $display("FAIL flush_pre: got a=%0d want 4", imem_bus.imem_addr); end
    flush_D = 1'b1;
    tick();
    flush_D = 1'b0;
    checks++; if (valid_D !== 1'b0 || instr_D !== 32'h0 || pc_D !== 64'h0) begin errors++; $display("FAIL flush_bubble: got v=%b i=%h pc=%h want bubble", valid_D, instr_D, pc_D); end
    checks++; if (imem_bus.imem_addr !== 7'd5 || fetch_count !== 32'd4) begin errors++; $display("FAIL flush_pc: got a=%0d cnt=%0d want 5 4", imem_bus.imem_addr, fetch_count); end
    tick();
    checks++; if (pc_D !== 64'h14 || instr_D !== 32'hA000_0005 || fetch_count !== 32'd5) begin errors++; $display("FAIL flush_after: got pc=%h i=%h cnt=%0d want 14 A0000005 5", pc_D, instr_D, fetch_count); end
  endtask

  task automatic test_stall_flush();
    stall_F = 1'b1; flush_D = 1'b1;
    tick();
    stall_F = 1'b0; flush_D = 1'b0;
    checks++; if (valid_D !== 1'b0 || imem_bus.imem_addr !== 7'd6 || fetch_count !== 32'd5) begin errors++; $display("FAIL stallflush: got v=%b a=%0d cnt=%0d want 0 6 5", valid_D, imem_bus.imem_addr, fetch_count); end
    tick();
    checks++; if (pc_D !== 64'h18 || instr_D !== 32'hA000_0006 || fetch_count !== 32'd6) begin errors++; $display("FAIL stallflush_after: got pc=%h i=%h cnt=%0d want 18 A0000006 6", pc_D, instr_D, fetch_count); end
  endtask

  task automatic test_redirect_stall();
    pc_src = 1'b1; pc_branch = 64'h58; stall_F = 1'b1; flush_D = 1'b1;
    tick();
    pc_src = 1'b0; stall_F = 1'b0; flush_D = 1'b0;
    checks++; if (valid_D !== 1'b0 || imem_bus.imem_addr !== 7'd22 || fetch_count !== 32'd6) begin errors++; $display("FAIL redirect: got v=%b a=%0d cnt=%0d want 0 22 6", valid_D, imem_bus.imem_addr, fetch_count); end
    tick();
    checks++; if (instr_D !== 32'hA000_0016 || pc_D !== 64'h58 || valid_D !== 1'b1) begin errors++; $display("FAIL redirect_fetch: got i=%h pc=%h v=%b want A0000016 58 1", instr_D, pc_D, valid_D); end
  endtask

  task automatic test_wrap();
    pc_src = 1'b1; pc_branch = 64'h1FC;
    tick();
    pc_src = 1'b0;
    checks++; if (imem_bus.imem_addr !== 7'd127 || valid_D !== 1'b0) begin errors++; $display("FAIL wrap_addr127: got a=%0d v=%b want 127 0", imem_bus.imem_addr, valid_D); end
    tick();
    checks++; if (pc_D !== 64'h1FC || instr_D !== 32'hA000_007F || imem_bus.imem_addr !== 7'd0) begin errors++; $display("FAIL wrap_alias: got pc=%h i=%h a=%0d want 1fc A000007F 0", pc_D, instr_D, imem_bus.imem_addr); end
    tick();
    checks++; if (pc_D !== 64'h200 || instr_D !== 32'hA000_0000 || fetch_count !== 32'd9) begin errors++; $display("FAIL wrap_200: got pc=%h i=%h cnt=%0d want 200 A0000000 9", pc_D, instr_D, fetch_count); end
  endtask

  task automatic test_pc_wrap();
    pc_src = 1'b1; pc_branch = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    pc_src = 1'b0;
    checks++; if (imem_bus.imem_addr !== 7'd127) begin errors++; $display("FAIL pcwrap_top: got a=%0d want 127", imem_bus.imem_addr); end
    tick();
    checks++; if (pc_D !== 64'hFFFF_FFFF_FFFF_FFFC || imem_bus.imem_addr !== 7'd0) begin errors++; $display("FAIL pcwrap_edge: got pc=%h a=%0d want fffffffffffffffc 0", pc_D, imem_bus.imem_addr); end
    tick();
    checks++; if (pc_D !== 64'h0 || instr_D !== 32'hA000_0000 || valid_D !== 1'b1 || fetch_count !== 32'd11) begin errors++; $display("FAIL pcwrap_zero: got pc=%h i=%h v=%b cnt=%0d want 0 A0000000 1 11", pc_D, instr_D, valid_D, fetch_count); end
  endtask

  task automatic test_async_reset();
    stall_F = 1'b1;
    tick();
    #3;
    reset = 1'b1;
    #1;
    checks++; if (valid_D !== 1'b0 || instr_D !== 32'h0 || pc_D !== 64'h0 || fetch_count !== 32'd0) begin errors++; $display("FAIL async_ifid: got v=%b i=%h pc=%h cnt=%0d want zeros", valid_D, instr_D, pc_D, fetch_count); end
    checks++; if (imem_bus.imem_en !== 1'b0 || imem_bus.imem_addr !== 7'd0) begin errors++; $display("FAIL async_imem: got en=%b a=%0d want 0 0", imem_bus.imem_en, imem_bus.imem_addr); end
    stall_F = 1'b0;
    tick();
    reset = 1'b0;
    checks++; if (imem_bus.imem_en !== 1'b0) begin errors++; $display("FAIL reboot_en: got %b want 0", imem_bus.imem_en); end
    tick();
    checks++; if (valid_D !== 1'b0 || imem_bus.imem_en !== 1'b1) begin errors++; $display("FAIL reboot_edge1: got v=%b en=%b want 0 1", valid_D, imem_bus.imem_en); end
    tick();
    checks++; if (instr_D !== 32'hA000_0000 || pc_D !== 64'h0 || valid_D !== 1'b1 || fetch_count !== 32'd1) begin errors++; $display("FAIL reboot_edge2: got i=%h pc=%h v=%b cnt=%0d want A0000000 0 1 1", instr_D, pc_D, valid_D, fetch_count); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_flush();
    test_stall_flush();
    test_redirect_stall();
    test_wrap();
    test_pc_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
